// File: rtl/int_vector_decoder.sv
// Interrupt vector decoder: runs the req/ack/eoi handshake for one interrupt at a time
// and turns the serviced priority code back into a one-hot clear pulse.
module ivd_line (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    input  logic svc_set,
    input  logic svc_drop,
    output logic in_service,
    output logic int_clr
);
    logic isv_q, isv_d;
    logic clr_q, clr_d;

    always_comb begin
        isv_d = isv_q;
        if (svc_set && hit)
            isv_d = 1'b1;
        else if (svc_drop)
            isv_d = 1'b0;
        clr_d = svc_drop && hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            isv_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            isv_q <= isv_d;
            clr_q <= clr_d;
        end
    end

    assign in_service = isv_q;
    assign int_clr    = clr_q;
endmodule

module int_vector_decoder #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_WIDTH    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] int_code,
    input  logic       int_ack,
    input  logic       int_eoi,
    output logic       int_req,
    output logic [2:0] int_vector,
    output logic [5:0] int_clr,
    output logic [5:0] in_service,
    output logic       ack_timeout,
    output logic       bad_code
);
    localparam int NUM_LINES = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            vec_q, vec_d;
    logic                  req_q, req_d;
    logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
    logic                  to_q, to_d;
    logic                  bad_q, bad_d;

    logic                  code_valid, code_bad, cnt_expired;
    logic                  svc_set, svc_drop;
    logic [NUM_LINES-1:0]  hit_vec;

    assign code_valid  = (int_code != 3'd0) && (int_code != 3'd7);
    assign code_bad    = (int_code == 3'd7);
    assign cnt_expired = (cnt_q == TO_WIDTH'(ACK_TIMEOUT - 1));

    // Per-line in-service/clear cells key off the latched vector, so an ack that
    // coincides with a preempting code still marks the originally requested line.
    assign svc_set  = (state_q == REQ) && int_ack;
    assign svc_drop = (state_q == SERVICE) && int_eoi;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        bad_d   = bad_q;
        case (state_q)
            IDLE: begin
                if (code_valid) begin
                    vec_d   = int_code;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end else if (code_bad) begin
                    bad_d = 1'b1;
                end
            end
            REQ: begin
                if (code_bad)
                    bad_d = 1'b1;
                if (int_ack) begin
                    req_d   = 1'b0;
                    state_d = SERVICE;
                end else if (cnt_expired) begin
                    // Abandon takes precedence so a late preemption cannot outrun the timeout.
                    req_d   = 1'b0;
                    vec_d   = 3'd0;
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                    if (code_valid && (int_code > vec_q))
                        vec_d = int_code;
                end
            end
            SERVICE: begin
                if (int_eoi)
                    state_d = CLEAR;
            end
            CLEAR: begin
                vec_d   = 3'd0;
                state_d = IDLE;
            end
            default: begin
                vec_d   = 3'd0;
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            bad_q   <= bad_d;
        end
    end

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        assign hit_vec[i] = (vec_q == 3'(i + 1));
        ivd_line u_line (
            .clk        (clk),
            .reset      (reset),
            .hit        (hit_vec[i]),
            .svc_set    (svc_set),
            .svc_drop   (svc_drop),
            .in_service (in_service[i]),
            .int_clr    (int_clr[i])
        );
    end

    assign int_req     = req_q;
    assign int_vector  = vec_q;
    assign ack_timeout = to_q;
    assign bad_code    = bad_q;
endmodule

// File: tb/tb_int_vector_decoder.sv
// Directed bench for int_vector_decoder: driver queues expected outputs, monitor checks them.
module tb_int_vector_decoder;
    typedef struct packed {
        logic       req;
        logic [2:0] vec;
        logic [5:0] isv;
        logic [5:0] clr;
        logic       to;
        logic       bad;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] int_code = 3'd0;
    logic       int_ack = 1'b0;
    logic       int_eoi = 1'b0;
    logic       int_req;
    logic [2:0] int_vector;
    logic [5:0] int_clr;
    logic [5:0] in_service;
    logic       ack_timeout;
    logic       bad_code;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    int_vector_decoder #(.ACK_TIMEOUT(4), .TO_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .int_code    (int_code),
        .int_ack     (int_ack),
        .int_eoi     (int_eoi),
        .int_req     (int_req),
        .int_vector  (int_vector),
        .int_clr     (int_clr),
        .in_service  (in_service),
        .ack_timeout (ack_timeout),
        .bad_code    (bad_code)
    );

    always #5 clk = ~clk;

    // Monitor: outputs settle after each rising edge; compare with oldest expectation.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{int_req, int_vector, in_service, int_clr, ack_timeout, bad_code};
                checks++;
                step++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL step%0d outputs got req=%b vec=%0d isv=%b clr=%b to=%b bad=%b exp req=%b vec=%0d isv=%b clr=%b to=%b bad=%b",
                             step, a.req, a.vec, a.isv, a.clr, a.to, a.bad,
                             e.req, e.vec, e.isv, e.clr, e.to, e.bad);
                end
            end
        end
    end

    // One cycle of stimulus plus the outputs expected after the next rising edge.
    task automatic cyc(input logic rst, input logic [2:0] code, input logic ack, input logic eoi,
                       input logic x_req, input logic [2:0] x_vec, input logic [5:0] x_isv,
                       input logic [5:0] x_clr, input logic x_to, input logic x_bad);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        int_code = code;
        int_ack  = ack;
        int_eoi  = eoi;
        e = '{x_req, x_vec, x_isv, x_clr, x_to, x_bad};
        q.push_back(e);
    endtask

    initial begin
        // reset, then idle
        cyc(1, 0, 0, 0,  0, 0, 6'b0, 6'b0, 0, 0);
        cyc(1, 0, 0, 0,  0, 0, 6'b0, 6'b0, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc(0, 0, 0, 0,  0, 0, 6'b0, 6'b0, 0, 0);

        // basic handshake on code 3
        cyc(0, 3, 0, 0,  1, 3, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 0, 1, 0,  0, 3, 6'b000100, 6'b000000, 0, 0);
        cyc(0, 0, 0, 0,  0, 3, 6'b000100, 6'b000000, 0, 0);
        cyc(0, 0, 0, 1,  0, 3, 6'b000000, 6'b000100, 0, 0);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 0);

        // preemption 2 -> 5 before ack
        cyc(0, 2, 0, 0,  1, 2, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 5, 0, 0,  1, 5, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 0, 1, 0,  0, 5, 6'b010000, 6'b000000, 0, 0);
        cyc(0, 0, 0, 1,  0, 5, 6'b000000, 6'b010000, 0, 0);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 0);

        // ack and higher code together: ack wins, vector stays 4; code ignored in SERVICE
        cyc(0, 4, 0, 0,  1, 4, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 6, 1, 0,  0, 4, 6'b001000, 6'b000000, 0, 0);
        cyc(0, 6, 0, 0,  0, 4, 6'b001000, 6'b000000, 0, 0);
        cyc(0, 0, 0, 1,  0, 4, 6'b000000, 6'b001000, 0, 0);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 0);

        // timeout with ACK_TIMEOUT=4: req high 4 cycles, then ack_timeout pulse, no clr
        cyc(0, 1, 0, 0,  1, 1, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 0, 0, 0,  1, 1, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 0, 0, 0,  1, 1, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 0, 0, 0,  1, 1, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 1, 0);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 0);

        // illegal code in IDLE: sticky bad_code, no request
        cyc(0, 7, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 1);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 1);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 1);

        // code 2 held through CLEAR: re-request 2 cycles after int_clr
        cyc(0, 2, 0, 0,  1, 2, 6'b000000, 6'b000000, 0, 1);
        cyc(0, 2, 1, 0,  0, 2, 6'b000010, 6'b000000, 0, 1);
        cyc(0, 2, 0, 1,  0, 2, 6'b000000, 6'b000010, 0, 1);
        cyc(0, 2, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 1);
        cyc(0, 2, 0, 0,  1, 2, 6'b000000, 6'b000000, 0, 1);

        // reset clears everything including bad_code; then service line 5
        cyc(1, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 6, 0, 0,  1, 6, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 0, 1, 0,  0, 6, 6'b100000, 6'b000000, 0, 0);
        cyc(0, 7, 0, 0,  0, 6, 6'b100000, 6'b000000, 0, 0);
        // reset in SERVICE together with eoi: no clear pulse, back to IDLE
        cyc(1, 0, 0, 1,  0, 0, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 0);

        // IDLE again; illegal and lower codes in REQ leave vector alone
        cyc(0, 3, 0, 0,  1, 3, 6'b000000, 6'b000000, 0, 0);
        cyc(0, 7, 0, 0,  1, 3, 6'b000000, 6'b000000, 0, 1);
        cyc(0, 1, 0, 0,  1, 3, 6'b000000, 6'b000000, 0, 1);
        cyc(0, 0, 1, 0,  0, 3, 6'b000100, 6'b000000, 0, 1);
        cyc(0, 0, 0, 1,  0, 3, 6'b000000, 6'b000100, 0, 1);
        cyc(0, 0, 0, 0,  0, 0, 6'b000000, 6'b000000, 0, 1);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
